// File: rtl/snoop_event_tracker_pkg.sv
// snoop_event_tracker_pkg: shared snoop type codes, CR response layout and type helper.
package snoop_event_tracker_pkg;

    typedef enum logic [3:0] {
        SNP_READ_ONCE             = 4'b0000,
        SNP_READ_SHARED           = 4'b0001,
        SNP_READ_CLEAN            = 4'b0010,
        SNP_READ_NOT_SHARED_DIRTY = 4'b0011,
        SNP_READ_UNIQUE           = 4'b0111,
        SNP_CLEAN_SHARED          = 4'b1000,
        SNP_CLEAN_INVALID         = 4'b1001,
        SNP_CLEAN_UNIQUE          = 4'b1011,
        SNP_MAKE_INVALID          = 4'b1101
    } snoop_type_e;

    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    localparam int TsWidth = 16;

    function automatic logic is_known_snoop(input logic [3:0] t);
        return t inside {SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN,
                         SNP_READ_NOT_SHARED_DIRTY, SNP_READ_UNIQUE, SNP_CLEAN_SHARED,
                         SNP_CLEAN_INVALID, SNP_CLEAN_UNIQUE, SNP_MAKE_INVALID};
    endfunction

endpackage

// File: rtl/snoop_event_tracker_fifo.sv
// snoop_type_fifo: in-order FIFO; a simultaneous push/pop reads the old head and may push while full.
module snoop_type_fifo #(
    parameter int Width = 4,
    parameter int Depth = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [Width-1:0]             wdata_i,
    output logic [Width-1:0]             rdata_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = $clog2(Depth+1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wptr, rptr;
    logic             do_push, do_pop;

    assign full_o  = count_o == CntW'(Depth);
    assign empty_o = count_o == '0;
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem[rptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr    <= '0;
            rptr    <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wptr <= wptr + PtrW'(1);
            if (do_pop)  rptr <= rptr + PtrW'(1);
            count_o <= count_o + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr] <= wdata_i;
    end

endmodule

// File: rtl/snoop_event_tracker.sv
// snoop_event_tracker: pairs ACE AC/CR handshakes in order and emits registered per-type completion pulses.
// Optional SNOOP_EVT_LATENCY_EN adds 16-bit timestamps and the snoop_slow_o latency pulse.
module snoop_event_tracker
    import snoop_event_tracker_pkg::*;
#(
    parameter int Depth     = 4,
    parameter int LatThresh = 64
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         ac_valid_i,
    input  logic                         ac_ready_i,
    input  logic [3:0]                   ac_snoop_i,
    input  logic                         cr_valid_i,
    input  logic                         cr_ready_i,
    input  logic [4:0]                   cr_resp_i,
    input  logic                         err_clr_i,
    output logic                         snoop_read_once_o,
    output logic                         snoop_read_shrd_o,
    output logic                         snoop_read_clean_o,
    output logic                         snoop_read_no_sd_o,
    output logic                         snoop_read_uniq_o,
    output logic                         snoop_clean_shrd_o,
    output logic                         snoop_clean_invld_o,
    output logic                         snoop_clean_uniq_o,
    output logic                         snoop_make_invld_o,
    output logic                         snoop_data_o,
    output logic                         snoop_slow_o,
    output logic [$clog2(Depth+1)-1:0]   outstanding_o,
    output logic                         proto_err_o
);

`ifdef SNOOP_EVT_LATENCY_EN
    localparam int EntW = 4 + TsWidth;
`else
    localparam int EntW = 4;
`endif

    logic            ac_hs, cr_hs, pop_ok, full, empty, err_set, slow_d;
    logic [EntW-1:0] wdata, rdata;
    logic [3:0]      head;
    cr_resp_t        resp;
    logic            unused_resp;

    assign ac_hs       = ac_valid_i & ac_ready_i;
    assign cr_hs       = cr_valid_i & cr_ready_i;
    assign pop_ok      = cr_hs & ~empty;
    assign resp        = cr_resp_i;
    assign unused_resp = ^{resp.was_unique, resp.is_shared, resp.pass_dirty, resp.error};
    assign head        = rdata[3:0];

`ifdef SNOOP_EVT_LATENCY_EN
    logic [TsWidth-1:0] ts, lat;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) ts <= '0;
        else         ts <= ts + TsWidth'(1);
    end
    assign wdata  = {ts, ac_snoop_i};
    // Modular subtraction absorbs a counter wrap between push and pop.
    assign lat    = ts - rdata[EntW-1:4];
    assign slow_d = pop_ok & (32'(lat) > LatThresh);
`else
    assign wdata  = ac_snoop_i;
    assign slow_d = 1'b0;
`endif

    snoop_type_fifo #(.Width(EntW), .Depth(Depth)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (ac_hs),
        .pop_i   (cr_hs),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    // A full FIFO with a pop in the same cycle accepts the push, so only a lone push overflows.
    assign err_set = (cr_hs & empty) | (ac_hs & full & ~cr_hs) | (pop_ok & ~is_known_snoop(head));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            snoop_read_once_o   <= 1'b0;
            snoop_read_shrd_o   <= 1'b0;
            snoop_read_clean_o  <= 1'b0;
            snoop_read_no_sd_o  <= 1'b0;
            snoop_read_uniq_o   <= 1'b0;
            snoop_clean_shrd_o  <= 1'b0;
            snoop_clean_invld_o <= 1'b0;
            snoop_clean_uniq_o  <= 1'b0;
            snoop_make_invld_o  <= 1'b0;
            snoop_data_o        <= 1'b0;
            snoop_slow_o        <= 1'b0;
            proto_err_o         <= 1'b0;
        end else begin
            snoop_read_once_o   <= pop_ok & (head == SNP_READ_ONCE);
            snoop_read_shrd_o   <= pop_ok & (head == SNP_READ_SHARED);
            snoop_read_clean_o  <= pop_ok & (head == SNP_READ_CLEAN);
            snoop_read_no_sd_o  <= pop_ok & (head == SNP_READ_NOT_SHARED_DIRTY);
            snoop_read_uniq_o   <= pop_ok & (head == SNP_READ_UNIQUE);
            snoop_clean_shrd_o  <= pop_ok & (head == SNP_CLEAN_SHARED);
            snoop_clean_invld_o <= pop_ok & (head == SNP_CLEAN_INVALID);
            snoop_clean_uniq_o  <= pop_ok & (head == SNP_CLEAN_UNIQUE);
            snoop_make_invld_o  <= pop_ok & (head == SNP_MAKE_INVALID);
            snoop_data_o        <= pop_ok & resp.data_transfer;
            snoop_slow_o        <= slow_d;
            proto_err_o         <= err_set | (proto_err_o & ~err_clr_i);
        end
    end

endmodule

// File: tb/tb_snoop_event_tracker.sv
// tb_snoop_event_tracker: directed stimulus with a pulse scoreboard drained by an independent monitor.
module tb_snoop_event_tracker;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ac_valid_i = 1'b0, ac_ready_i = 1'b0, cr_valid_i = 1'b0, cr_ready_i = 1'b0, err_clr_i = 1'b0;
    logic [3:0] ac_snoop_i = '0;
    logic [4:0] cr_resp_i = '0;
    logic       snoop_read_once_o, snoop_read_shrd_o, snoop_read_clean_o, snoop_read_no_sd_o;
    logic       snoop_read_uniq_o, snoop_clean_shrd_o, snoop_clean_invld_o, snoop_clean_uniq_o;
    logic       snoop_make_invld_o, snoop_data_o, snoop_slow_o, proto_err_o;
    logic [2:0] outstanding_o;

    snoop_event_tracker #(.Depth(4), .LatThresh(64)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .ac_valid_i          (ac_valid_i),
        .ac_ready_i          (ac_ready_i),
        .ac_snoop_i          (ac_snoop_i),
        .cr_valid_i          (cr_valid_i),
        .cr_ready_i          (cr_ready_i),
        .cr_resp_i           (cr_resp_i),
        .err_clr_i           (err_clr_i),
        .snoop_read_once_o   (snoop_read_once_o),
        .snoop_read_shrd_o   (snoop_read_shrd_o),
        .snoop_read_clean_o  (snoop_read_clean_o),
        .snoop_read_no_sd_o  (snoop_read_no_sd_o),
        .snoop_read_uniq_o   (snoop_read_uniq_o),
        .snoop_clean_shrd_o  (snoop_clean_shrd_o),
        .snoop_clean_invld_o (snoop_clean_invld_o),
        .snoop_clean_uniq_o  (snoop_clean_uniq_o),
        .snoop_make_invld_o  (snoop_make_invld_o),
        .snoop_data_o        (snoop_data_o),
        .snoop_slow_o        (snoop_slow_o),
        .outstanding_o       (outstanding_o),
        .proto_err_o         (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    localparam logic [10:0] RO = 11'h400, RS = 11'h200, RC = 11'h100, RNSD = 11'h080, RU = 11'h040;
    localparam logic [10:0] CS = 11'h020, CI = 11'h010, CU = 11'h008, MI = 11'h004, DAT = 11'h002, SLOW = 11'h001;

    typedef struct {int cyc; logic [10:0] v;} exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_checks = 0, n_fail = 0;
    logic [10:0] pulses;

    assign pulses = {snoop_read_once_o, snoop_read_shrd_o, snoop_read_clean_o, snoop_read_no_sd_o,
                     snoop_read_uniq_o, snoop_clean_shrd_o, snoop_clean_invld_o, snoop_clean_uniq_o,
                     snoop_make_invld_o, snoop_data_o, snoop_slow_o};

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every visible pulse vector must match the oldest expectation, in the expected cycle.
    always @(negedge clk_i) begin
        if (rst_ni && pulses != '0) begin
            if (sb.size() == 0) chk("unexpected_pulse", 32'(pulses), 32'h0);
            else begin
                mon_e = sb.pop_front();
                chk("pulse_vec", 32'(pulses), 32'(mon_e.v));
                chk("pulse_cycle", cyc, mon_e.cyc);
            end
        end
    end

    task automatic drive(input logic av, input logic [3:0] at, input logic cv, input logic [4:0] r, input logic clr);
        @(posedge clk_i);
        #1;
        ac_valid_i = av; ac_ready_i = 1'b1; ac_snoop_i = at;
        cr_valid_i = cv; cr_ready_i = 1'b1; cr_resp_i = r; err_clr_i = clr;
    endtask

    task automatic idle();
        drive(1'b0, 4'h0, 1'b0, 5'h0, 1'b0);
    endtask

    task automatic exp_pulse(input logic [10:0] v);
        sb.push_back('{cyc + 1, v});
    endtask

    task automatic push(input logic [3:0] t);
        drive(1'b1, t, 1'b0, 5'h0, 1'b0);
    endtask

    task automatic pop(input logic [4:0] r, input logic [10:0] v);
        drive(1'b0, 4'h0, 1'b1, r, 1'b0);
        if (v != '0) exp_pulse(v);
    endtask

    task automatic clear_err();
        drive(1'b0, 4'h0, 1'b0, 5'h0, 1'b1);
        idle();
        @(negedge clk_i);
        chk("err_cleared", 32'(proto_err_o), 32'h0);
    endtask

    task automatic settle_chk(input int outs, input logic err);
        idle();
        @(negedge clk_i);
        chk("outstanding", 32'(outstanding_o), outs);
        chk("proto_err", 32'(proto_err_o), 32'(err));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        ac_valid_i = 1'b0; cr_valid_i = 1'b0; err_clr_i = 1'b0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("reset_pulses", 32'(pulses), 32'h0);
        chk("reset_outstanding", 32'(outstanding_o), 32'h0);
        chk("reset_err", 32'(proto_err_o), 32'h0);

        // Single ReadShared with data, CR two cycles after AC
        push(4'b0001);
        settle_chk(1, 1'b0);
        pop(5'b00001, RS | DAT);
        settle_chk(0, 1'b0);

        // Back-to-back pushes and pops: consecutive pulses in order
        push(4'b0000); push(4'b0111); push(4'b1101);
        pop(5'b00000, RO); pop(5'b00001, RU | DAT); pop(5'b00000, MI);
        settle_chk(0, 1'b0);

        // Full FIFO: simultaneous push/pop keeps count, lone push overflows
        push(4'b1000); push(4'b1001); push(4'b1011); push(4'b0010);
        settle_chk(4, 1'b0);
        drive(1'b1, 4'b0011, 1'b1, 5'b00000, 1'b0);
        exp_pulse(CS);
        settle_chk(4, 1'b0);
        push(4'b0001);
        settle_chk(4, 1'b1);
        clear_err();
        pop(5'b00010, CI); pop(5'b00011, CU | DAT); pop(5'b00000, RC); pop(5'b00001, RNSD | DAT);
        settle_chk(0, 1'b0);

        // Pop on empty, clear, and set-beats-clear
        pop(5'b00001, '0);
        settle_chk(0, 1'b1);
        clear_err();
        drive(1'b0, 4'h0, 1'b1, 5'b00000, 1'b1);
        settle_chk(0, 1'b1);
        clear_err();

        // Unknown type: data only, error flagged
        push(4'b0100);
        pop(5'b00001, DAT);
        settle_chk(0, 1'b1);
        clear_err();

        // One entry with simultaneous push/pop returns the old head
        push(4'b0001);
        drive(1'b1, 4'b0111, 1'b1, 5'b00000, 1'b0);
        exp_pulse(RS);
        settle_chk(1, 1'b0);
        pop(5'b00000, RU);
        settle_chk(0, 1'b0);

        // Valid without ready is not a handshake
        @(posedge clk_i);
        #1;
        ac_valid_i = 1'b1; ac_ready_i = 1'b0; cr_valid_i = 1'b1; cr_ready_i = 1'b0;
        settle_chk(0, 1'b0);

`ifdef SNOOP_EVT_LATENCY_EN
        push(4'b0000);
        repeat (63) idle();
        pop(5'b00000, RO);
        push(4'b0000);
        repeat (64) idle();
        pop(5'b00000, RO | SLOW);
        settle_chk(0, 1'b0);
        do_reset();
        repeat (16'hFFEF) @(posedge clk_i);
        push(4'b0001);
        repeat (64) idle();
        pop(5'b00000, RS | SLOW);
        settle_chk(0, 1'b0);
`endif

        // Reset with entries in flight discards them
        push(4'b0000); push(4'b0001); push(4'b0010);
        settle_chk(3, 1'b0);
        #1 rst_ni = 1'b0;
        #1;
        chk("async_rst_outstanding", 32'(outstanding_o), 32'h0);
        chk("async_rst_pulses", 32'(pulses), 32'h0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        settle_chk(0, 1'b0);
        chk("post_rst_pulses", 32'(pulses), 32'h0);
        pop(5'b00001, '0);
        settle_chk(0, 1'b1);
        repeat (3) idle();

        chk("scoreboard_drained", sb.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
